conv_result_writer: RTL and testbench

//  Sink end of the convolution datapath. Accepts the stream of scalar MMU results
//  (one per output pixel), adds a per-channel bias, applies optional ReLU, and writes

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_sat_relu.sv | 27 ++
 rtl/conv_result_writer.sv | 152 +++++++++++++++
 tb/tb_conv_result_writer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution result writer.
package conv_pkg;

  localparam int unsigned OUT_CHANNEL_D = 6;
  localparam int unsigned OUT_ROW_D     = 28;
  localparam int unsigned OUT_COL_D     = 28;
  localparam int unsigned DATA_W_D      = 32;
  localparam int unsigned ADDR_W_D      = 13;
  localparam int unsigned FRAME_PX_D    = OUT_CHANNEL_D * OUT_ROW_D * OUT_COL_D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/conv_sat_relu.sv
// Bias add with signed saturation followed by optional ReLU (purely combinational).
module conv_sat_relu
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_D,
  parameter int unsigned RELU_EN = 1
) (
  input  logic [DATA_W-1:0] i_res,
  input  logic [DATA_W-1:0] i_bias,
  output logic [DATA_W-1:0] o_pix
);

  logic [DATA_W:0] w_sum;

  // One extra bit of headroom; top two bits disagreeing means the sum left the DATA_W range.
  always_comb begin
    w_sum = {i_res[DATA_W-1], i_res} + {i_bias[DATA_W-1], i_bias};
    o_pix = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      o_pix = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    if ((RELU_EN != 0) && o_pix[DATA_W-1]) begin
      o_pix = '0;
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Sink of the convolution datapath: biases, clamps and writes one frame of pixels
// in (channel, row, col) order to the output feature-map memory.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int unsigned OUT_CHANNEL = OUT_CHANNEL_D,
  parameter int unsigned OUT_ROW     = OUT_ROW_D,
  parameter int unsigned OUT_COL     = OUT_COL_D,
  parameter int unsigned DATA_W      = DATA_W_D,
  parameter int unsigned ADDR_W      = ADDR_W_D,
  parameter int unsigned RELU_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              bias_we,
  input  logic [2:0]        bias_idx,
  input  logic [DATA_W-1:0] bias_wdata,
  output logic              mem_we,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N_W = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;
  localparam int unsigned X_W = (OUT_ROW > 1) ? $clog2(OUT_ROW) : 1;
  localparam int unsigned Y_W = (OUT_COL > 1) ? $clog2(OUT_COL) : 1;

  localparam logic [N_W-1:0] N_LAST = N_W'(OUT_CHANNEL - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(OUT_ROW - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(OUT_COL - 1);

  state_t            r_state;
  logic [N_W-1:0]    r_n;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_done;
  logic [DATA_W-1:0] r_bias [OUT_CHANNEL];

  logic              w_accept;
  logic              w_last;
  logic              w_bias_wr;
  logic [DATA_W-1:0] w_pix;

  conv_sat_relu #(
    .DATA_W  (DATA_W),
    .RELU_EN (RELU_EN)
  ) u_sat_relu (
    .i_res  (res_data),
    .i_bias (r_bias[r_n]),
    .o_pix  (w_pix)
  );

  // Handshake decode and output fan-out from the holding registers.
  always_comb begin
    res_ready = (r_state == RUN) && (!r_mem_we || mem_wready);
    w_accept  = res_valid && res_ready;
    w_last    = (r_n == N_LAST) && (r_x == X_LAST) && (r_y == Y_LAST);
    w_bias_wr = bias_we && (r_state == IDLE) && (32'(bias_idx) < OUT_CHANNEL);
    busy      = (r_state != IDLE);
    mem_we    = r_mem_we;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    done      = r_done;
  end

  // Per-channel bias registers, writable only between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_CHANNEL; i++) begin
        r_bias[i] <= '0;
      end
    end else if (w_bias_wr) begin
      r_bias[bias_idx[N_W-1:0]] <= bias_wdata;
    end
  end

  // Frame FSM, pixel counters and the single-entry write holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A new accept overwrites the slot in the same cycle the old write drains.
      if (w_accept) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_pix;
      end else if (mem_wready) begin
        r_mem_we <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_last) begin
              r_state <= DRAIN;
              r_n     <= '0;
              r_x     <= '0;
              r_y     <= '0;
              r_addr  <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (r_y == Y_LAST) begin
                r_y <= '0;
                if (r_x == X_LAST) begin
                  r_x <= '0;
                  r_n <= r_n + 1'b1;
                end else begin
                  r_x <= r_x + 1'b1;
                end
              end else begin
                r_y <= r_y + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (!r_mem_we || mem_wready) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer: a pixel-stream scoreboard built from
// the bias/saturate/ReLU rules, plus literal spot checks on a second small instance.
module tb_conv_result_writer;

  localparam int FRAME = 4704;
  localparam int CH_PX = 784;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, res_valid, res_ready, bias_we, mem_we, mem_wready, busy, done;
  logic [31:0] res_data, bias_wdata, mem_wdata;
  logic [2:0]  bias_idx;
  logic [12:0] mem_addr;

  logic        start2, res_valid2, res_ready2, bias_we2, mem_we2, mem_wready2, busy2, done2;
  logic [31:0] res_data2, bias_wdata2, mem_wdata2;
  logic [2:0]  bias_idx2;
  logic [3:0]  mem_addr2;

  always #5 clk = ~clk;

  conv_result_writer #(.RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .bias_we(bias_we), .bias_idx(bias_idx), .bias_wdata(bias_wdata),
    .mem_we(mem_we), .mem_wready(mem_wready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  conv_result_writer #(
    .OUT_CHANNEL(3), .OUT_ROW(2), .OUT_COL(2), .DATA_W(32), .ADDR_W(4), .RELU_EN(0)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .res_valid(res_valid2), .res_data(res_data2),
    .res_ready(res_ready2), .bias_we(bias_we2), .bias_idx(bias_idx2), .bias_wdata(bias_wdata2),
    .mem_we(mem_we2), .mem_wready(mem_wready2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference pixel rule: wide signed sum, clamp to 32-bit range, optional ReLU.
  function automatic logic [31:0] pix_f(input logic [31:0] r, input logic [31:0] b, input bit relu);
    longint s;
    s = longint'($signed(r)) + longint'($signed(b));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (relu && s < 0) s = 0;
    return s[31:0];
  endfunction

  function automatic logic [31:0] gen(input int mode, input int k);
    case (mode)
      0: return 32'(k);
      1: begin
        if (k == 0) return 32'h7FFF_FFFF;
        if (k == 1568) return 32'd5;
        return 32'(k - 2352);
      end
      2: return 32'(k * 5 - 300);
      default: return (k % 2 == 1) ? 32'(-k) : 32'(3 * k);
    endcase
  endfunction

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] bias_m [6];
  logic [31:0] mem_img [FRAME];
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          done_cnt = 0;
  int          nwr = 0;

  // Scoreboard: every accepted memory write and every done pulse of the main instance.
  initial begin
    bit          prev_stall;
    logic [12:0] prev_addr;
    logic [31:0] prev_data;
    wr_t         e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_we", mem_we, 1);
          chk("hold_addr", mem_addr, prev_addr);
          chk("hold_data", mem_wdata, prev_data);
        end
        if (mem_we && mem_wready) begin
          if (exp_q.size() == 0) begin
            chk("extra_write_addr", mem_addr, 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
          end
          if (mem_addr < FRAME) mem_img[mem_addr] = mem_wdata;
          nwr++;
          last_wr_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          chk("done_busy_low", busy, 0);
          chk("done_after_last_wr", cyc, last_wr_cyc + 1);
          chk("done_queue_empty", exp_q.size(), 0);
        end
        prev_stall = mem_we && !mem_wready;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
      end
    end
  end

  task automatic write_bias(input int idx, input logic [31:0] val);
    bias_we    = 1'b1;
    bias_idx   = 3'(idx);
    bias_wdata = val;
    @(posedge clk); #1;
    bias_we = 1'b0;
    if (idx < 6) bias_m[idx] = val;
  endtask

  task automatic drive_frame(input int mode, input bit stall, input bit poke50,
                             input int abort_at, input bit drain_stall, output bit aborted);
    int  k, guard, hold, d0, w;
    bit  acc, poked;
    logic [31:0] px;
    wr_t e;
    k = 0; guard = 0; hold = 0; poked = 0; aborted = 0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bias_we = 1'b0;
    while (k < FRAME && guard < 30000) begin
      guard++;
      res_data = gen(mode, k);
      if (hold > 0) begin
        res_valid = 1'b1; mem_wready = 1'b0;
      end else if (stall) begin
        res_valid  = ($urandom_range(0, 3) != 0);
        mem_wready = ($urandom_range(0, 2) != 0);
      end else begin
        res_valid = 1'b1; mem_wready = 1'b1;
      end
      if (poke50 && k == 50 && !poked) begin
        poked = 1; start = 1'b1; bias_we = 1'b1; bias_idx = 3'd0; bias_wdata = 32'd999;
      end
      @(negedge clk);
      acc = res_valid && res_ready;
      if (hold > 0) begin
        chk("stall_res_ready", res_ready, 0);
        chk("stall_mem_we", mem_we, 1);
        hold--;
      end
      @(posedge clk); #1;
      start = 1'b0; bias_we = 1'b0;
      if (acc) begin
        px = pix_f(gen(mode, k), bias_m[k / CH_PX], 1'b1);
        e.addr = k; e.data = px;
        exp_q.push_back(e);
        k++;
        if (stall && k == 2000) hold = 3;
        if (k == abort_at) begin
          aborted = 1;
          break;
        end
      end
    end
    if (guard >= 30000) chk("frame_timeout", k, FRAME);
    if (aborted) return;
    if (drain_stall) begin
      res_valid = 1'b1; res_data = 32'd77; mem_wready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("drain_res_ready", res_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_no_done", done, 0);
        @(posedge clk); #1;
      end
    end
    res_valid = 1'b0; mem_wready = 1'b1;
    w = 0;
    while (done_cnt == d0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    @(posedge clk); #1;
    chk("single_done", done_cnt, d0 + 1);
    chk("idle_busy", busy, 0);
  endtask

  // Second instance: small frame, RELU off, literal expectations only.
  logic [31:0] img2 [16];
  int          nwr2 = 0;
  int          done2_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_we2 && mem_wready2) begin
        img2[mem_addr2] = mem_wdata2;
        nwr2++;
      end
      if (!rst && done2) done2_cnt++;
    end
  end

  initial begin
    bit ab;
    int k2, g2;
    bit acc2;
    logic [31:0] r2;

    rst = 1'b1;
    start = 0; res_valid = 0; res_data = '0; bias_we = 0; bias_idx = '0; bias_wdata = '0;
    mem_wready = 1'b1;
    start2 = 0; res_valid2 = 0; res_data2 = '0; bias_we2 = 0; bias_idx2 = '0; bias_wdata2 = '0;
    mem_wready2 = 1'b1;
    for (int i = 0; i < 6; i++) bias_m[i] = '0;
    for (int i = 0; i < FRAME; i++) mem_img[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) img2[i] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: zero bias, identity data.
    drive_frame(0, 0, 0, -1, 0, ab);
    chk("f1_writes", nwr, FRAME);
    chk("f1_px0", mem_img[0], 32'd0);
    chk("f1_px1234", mem_img[1234], 32'd1234);
    chk("f1_px4703", mem_img[4703], 32'd4703);
    chk("f1_done_cnt", done_cnt, 1);

    // Frame 2: mixed biases, saturation and ReLU; bias[5] written with start.
    write_bias(0, 32'd1);
    write_bias(2, 32'hFFFF_FFF6);
    write_bias(3, 32'd7);
    write_bias(4, 32'hFFFF_FFFD);
    write_bias(6, 32'd12345);
    bias_we = 1'b1; bias_idx = 3'd5; bias_wdata = 32'd100; bias_m[5] = 32'd100;
    drive_frame(1, 0, 0, -1, 0, ab);
    chk("f2_sat_pos", mem_img[0], 32'h7FFF_FFFF);
    chk("f2_relu_1568", mem_img[1568], 32'd0);
    chk("f2_relu_1569", mem_img[1569], 32'd0);
    chk("f2_ch3_first", mem_img[2352], 32'd7);
    chk("f2_last", mem_img[4703], 32'd2451);
    chk("f2_done_cnt", done_cnt, 2);

    // Frame 3: start/bias poke while busy, then reset at pixel 100.
    drive_frame(2, 0, 1, 100, 0, ab);
    chk("f3_aborted", ab, 1);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res_ready", res_ready, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) bias_m[i] = '0;
    res_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_done", done_cnt, 2);

    // Frame 4: restart from address 0 with random gaps, a forced stall and a stalled drain.
    drive_frame(3, 1, 0, -1, 1, ab);
    chk("f4_even", mem_img[4702], 32'd14106);
    chk("f4_odd_relu", mem_img[4703], 32'd0);
    chk("f4_first", mem_img[0], 32'd0);
    chk("f4_done_cnt", done_cnt, 3);

    // Small instance, RELU disabled.
    bias_we2 = 1'b1; bias_idx2 = 3'd0; bias_wdata2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bias_idx2 = 3'd2; bias_wdata2 = 32'hFFFF_FFF6;
    @(posedge clk); #1;
    bias_we2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k2 = 0; g2 = 0;
    while (k2 < 12 && g2 < 40) begin
      g2++;
      r2 = (k2 == 0) ? 32'h8000_0000 : (k2 == 8) ? 32'd5 : 32'(k2);
      res_valid2 = 1'b1; res_data2 = r2;
      @(negedge clk);
      acc2 = res_valid2 && res_ready2;
      @(posedge clk); #1;
      if (acc2) k2++;
    end
    res_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("d2_accepted", k2, 12);
    chk("d2_writes", nwr2, 12);
    chk("d2_done_cnt", done2_cnt, 1);
    chk("d2_sat_neg", img2[0], 32'h8000_0000);
    chk("d2_bias0", img2[1], 32'd0);
    chk("d2_bias1", img2[4], 32'd4);
    chk("d2_neg_pass", img2[8], 32'hFFFF_FFFB);
    chk("d2_neg_one", img2[9], 32'hFFFF_FFFF);
    chk("d2_last", img2[11], 32'd1);
    chk("d2_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
